// File: rtl/ccd_frame_writer_pkg.sv
// ccd_frame_writer_pkg: shared FSM state type and RGB565 conversion helper
package ccd_frame_writer_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DRAIN} state_t;
    localparam int RGB565_W = 16;
    function automatic logic [RGB565_W-1:0] to_rgb565(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        return {r[11:7], g[11:6], b[11:7]};
    endfunction
endpackage

// File: rtl/ccd_word_fifo.sv
// ccd_word_fifo: show-ahead synchronous FIFO; a full FIFO still accepts a push when popped in the same cycle
module ccd_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 32
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge iclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ccd_frame_writer.sv
// ccd_frame_writer: captures whole camera frames as packed RGB565 pairs and writes them over an Avalon-MM master
module ccd_frame_writer
    import ccd_frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic [11:0] ired,
    input  logic [11:0] igreen,
    input  logic [11:0] iblue,
    input  logic        idval,
    input  logic [31:0] iframe_cont,
    input  logic        ienable,
    input  logic [31:0] ibase_addr,
    output logic [31:0] oaddress,
    output logic        owrite,
    output logic [31:0] owritedata,
    input  logic        iwaitrequest,
    output logic        oframe_done,
    output logic        ooverflow,
    output logic        obusy
);
    localparam int PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int WORDS = PIXELS / 2;
    localparam int PW = $clog2(PIXELS + 1);
    localparam int WW = $clog2(WORDS + 1);
    state_t state, state_nxt;
    logic [31:0] last_frame_cont, next_addr, fifo_dout;
    logic [PW-1:0] pix_cnt;
    logic [WW-1:0] word_idx;
    logic [RGB565_W-1:0] px, even_px;
    logic odd_phase, aborted, frame_edge, frame_start, pix_ok, last_pix;
    logic push, pop, ovf, accept, fifo_full, fifo_empty;
    assign frame_edge = iframe_cont != last_frame_cont;
    assign frame_start = state == WAIT_FRAME && ienable && frame_edge;
    assign pix_ok = state == CAPTURE && idval && !frame_edge;
    assign last_pix = pix_ok && pix_cnt == PW'(PIXELS - 1);
    assign px = to_rgb565(ired, igreen, iblue);
    assign push = pix_ok && odd_phase;
    // the next word is popped in the accept cycle so back-to-back writes need no bubble
    assign pop = !fifo_empty && (!owrite || !iwaitrequest);
    assign ovf = push && fifo_full && !pop;
    assign accept = owrite && !iwaitrequest;
    ccd_word_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .iclk (iclk),
        .irst (irst),
        .push (push),
        .din  ({px, even_px}),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );
    always_ff @(posedge iclk) begin
        if (irst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = ienable ? WAIT_FRAME : IDLE;
            WAIT_FRAME: state_nxt = !ienable ? IDLE : frame_edge ? CAPTURE : WAIT_FRAME;
            CAPTURE:    state_nxt = (last_pix || ovf || frame_edge) ? DRAIN : CAPTURE;
            DRAIN:      state_nxt = (fifo_empty && !owrite) ? (ienable ? WAIT_FRAME : IDLE) : DRAIN;
            default:    state_nxt = IDLE;
        endcase
    end
    always_comb begin
        obusy = state == CAPTURE || state == DRAIN;
    end
    always_ff @(posedge iclk) begin
        last_frame_cont <= iframe_cont;
        if (irst) begin
            pix_cnt <= '0;
            word_idx <= '0;
            even_px <= '0;
            odd_phase <= 1'b0;
            aborted <= 1'b0;
            next_addr <= '0;
            owrite <= 1'b0;
            oaddress <= '0;
            owritedata <= '0;
            oframe_done <= 1'b0;
            ooverflow <= 1'b0;
        end else begin
            oframe_done <= accept && word_idx == WW'(WORDS - 1) && !aborted;
            if (ovf) ooverflow <= 1'b1;
            if (frame_start) begin
                pix_cnt <= '0;
                word_idx <= '0;
                odd_phase <= 1'b0;
                aborted <= 1'b0;
                next_addr <= ibase_addr;
            end else begin
                if (pix_ok) begin
                    pix_cnt <= pix_cnt + 1'b1;
                    odd_phase <= !odd_phase;
                    if (!odd_phase) even_px <= px;
                end
                if (state == CAPTURE && (ovf || frame_edge)) aborted <= 1'b1;
                if (accept) word_idx <= word_idx + 1'b1;
                if (pop) next_addr <= next_addr + 32'd4;
            end
            if (pop) begin
                owrite <= 1'b1;
                oaddress <= next_addr;
                owritedata <= fifo_dout;
            end else if (accept) begin
                owrite <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ccd_frame_writer.sv
// tb_ccd_frame_writer: directed vectors for a 4x2 instance plus a 4x4/depth-4 instance for overflow
module tb_ccd_frame_writer;
    logic iclk = 1'b0;
    logic irst, idval, ienable, iwaitrequest, iwaitrequest2;
    logic [11:0] ired, igreen, iblue;
    logic [31:0] iframe_cont, ibase_addr;
    logic [31:0] oaddress, owritedata, oaddress2, owritedata2;
    logic owrite, oframe_done, ooverflow, obusy;
    logic owrite2, oframe_done2, ooverflow2, obusy2;
    int checks = 0, failures = 0;
    int done_cnt = 0, acc2 = 0, done2 = 0;
    logic [31:0] acc_addr[$], acc_data[$];
    logic [11:0] pr[8], pg[8], pb[8];
    logic [31:0] exp_w[4];
    always #5 iclk = ~iclk;
    ccd_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(16)) dut (
        .iclk(iclk), .irst(irst), .ired(ired), .igreen(igreen), .iblue(iblue), .idval(idval),
        .iframe_cont(iframe_cont), .ienable(ienable), .ibase_addr(ibase_addr),
        .oaddress(oaddress), .owrite(owrite), .owritedata(owritedata), .iwaitrequest(iwaitrequest),
        .oframe_done(oframe_done), .ooverflow(ooverflow), .obusy(obusy)
    );
    ccd_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(4), .FIFO_DEPTH(4)) dut_ovf (
        .iclk(iclk), .irst(irst), .ired(ired), .igreen(igreen), .iblue(iblue), .idval(idval),
        .iframe_cont(iframe_cont), .ienable(ienable), .ibase_addr(ibase_addr),
        .oaddress(oaddress2), .owrite(owrite2), .owritedata(owritedata2), .iwaitrequest(iwaitrequest2),
        .oframe_done(oframe_done2), .ooverflow(ooverflow2), .obusy(obusy2)
    );
    always @(negedge iclk) begin
        if (owrite && !iwaitrequest) begin
            acc_addr.push_back(oaddress);
            acc_data.push_back(owritedata);
        end
        if (oframe_done) done_cnt++;
        if (owrite2 && !iwaitrequest2) acc2++;
        if (oframe_done2) done2++;
    end
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask
    task automatic send_pixels(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            ired = pr[(start + i) % 8];
            igreen = pg[(start + i) % 8];
            iblue = pb[(start + i) % 8];
            idval = 1'b1;
            tick(1);
        end
        idval = 1'b0;
    endtask
    initial begin
        int s, d, a2, d2, stable;
        pr = '{12'hFFF, 12'h000, 12'h800, 12'h080, 12'hFFF, 12'h07F, 12'hF80, 12'h000};
        pg = '{12'h000, 12'hFFF, 12'h400, 12'h040, 12'hFFF, 12'h03F, 12'h000, 12'h000};
        pb = '{12'hFFF, 12'h000, 12'h080, 12'h000, 12'hFFF, 12'h07F, 12'h000, 12'hF80};
        exp_w = '{32'h07E0_F81F, 32'h0820_8201, 32'h0000_FFFF, 32'h001F_F800};
        irst = 1'b1; idval = 1'b0; ienable = 1'b0; iwaitrequest = 1'b0; iwaitrequest2 = 1'b0;
        ired = '0; igreen = '0; iblue = '0; iframe_cont = '0; ibase_addr = '0;
        tick(2);
        chk("rst_owrite", {31'd0, owrite}, 32'd0);
        chk("rst_busy", {31'd0, obusy}, 32'd0);
        chk("rst_ovf", {31'd0, ooverflow}, 32'd0);
        chk("rst_done", {31'd0, oframe_done}, 32'd0);
        // full 4x2 frame on an idle bus
        irst = 1'b0; ienable = 1'b1;
        tick(2);
        ibase_addr = 32'h1000; iframe_cont = 32'd1;
        tick(1);
        chk("cap_busy", {31'd0, obusy}, 32'd1);
        send_pixels(8, 0);
        tick(20);
        chk("frame_words", acc_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("frame_addr%0d", i), acc_addr[i], 32'h1000 + 32'(4 * i));
            chk($sformatf("frame_data%0d", i), acc_data[i], exp_w[i]);
        end
        chk("frame_done", done_cnt, 32'd1);
        chk("frame_idle", {31'd0, obusy}, 32'd0);
        // first word held under waitrequest for five cycles
        s = acc_addr.size(); d = done_cnt;
        ibase_addr = 32'h2000; iwaitrequest = 1'b1; iframe_cont = 32'd2;
        tick(1);
        send_pixels(2, 0);
        for (int k = 0; k < 10 && !owrite; k++) tick(1);
        chk("stall_owrite", {31'd0, owrite}, 32'd1);
        stable = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) iwaitrequest = 1'b0;
            if (owrite && oaddress == 32'h2000 && owritedata == 32'h07E0_F81F) stable++;
            tick(1);
        end
        chk("stall_stable", stable, 32'd6);
        send_pixels(6, 2);
        tick(20);
        chk("stall_words", acc_addr.size() - s, 32'd4);
        chk("stall_addr0", acc_addr[s], 32'h2000);
        chk("stall_data0", acc_data[s], 32'h07E0_F81F);
        chk("stall_addr3", acc_addr[s+3], 32'h200C);
        chk("stall_done", done_cnt - d, 32'd1);
        // short frame aborts, next frame restarts at base
        s = acc_addr.size(); d = done_cnt;
        ibase_addr = 32'h3000; iframe_cont = 32'd3;
        tick(1);
        send_pixels(3, 0);
        iframe_cont = 32'd4;
        tick(10);
        chk("abort_words", acc_addr.size() - s, 32'd1);
        chk("abort_done", done_cnt - d, 32'd0);
        iframe_cont = 32'd5;
        tick(1);
        send_pixels(8, 0);
        tick(20);
        chk("refr_words", acc_addr.size() - s, 32'd5);
        chk("refr_addr0", acc_addr[s+1], 32'h3000);
        chk("refr_data0", acc_data[s+1], 32'h07E0_F81F);
        chk("refr_addr3", acc_addr[s+4], 32'h300C);
        chk("refr_done", done_cnt - d, 32'd1);
        // ienable dropped mid-frame: frame completes, then nothing more is captured
        s = acc_addr.size(); d = done_cnt;
        iframe_cont = 32'd6;
        tick(1);
        send_pixels(4, 0);
        ienable = 1'b0;
        send_pixels(4, 4);
        tick(20);
        chk("en_words", acc_addr.size() - s, 32'd4);
        chk("en_done", done_cnt - d, 32'd1);
        iframe_cont = 32'd7;
        tick(2);
        send_pixels(8, 0);
        tick(10);
        chk("en_ignored", acc_addr.size() - s, 32'd4);
        chk("en_idle", {31'd0, obusy}, 32'd0);
        // overflow on the depth-4 instance with the bus stalled
        irst = 1'b1;
        tick(2);
        irst = 1'b0; ienable = 1'b1; iwaitrequest2 = 1'b1;
        tick(2);
        a2 = acc2; d2 = done2;
        chk("ovf_clear", {31'd0, ooverflow2}, 32'd0);
        iframe_cont = 32'd8;
        tick(1);
        send_pixels(12, 0);
        tick(3);
        chk("ovf_flag", {31'd0, ooverflow2}, 32'd1);
        chk("ovf_stalled", acc2 - a2, 32'd0);
        iwaitrequest2 = 1'b0;
        tick(30);
        chk("ovf_words", acc2 - a2, 32'd5);
        chk("ovf_done", done2 - d2, 32'd0);
        chk("ovf_idle", {31'd0, obusy2}, 32'd0);
        chk("ovf_sticky", {31'd0, ooverflow2}, 32'd1);
        // reset mid-capture with a write pending
        ibase_addr = 32'h5000; iwaitrequest = 1'b1; iframe_cont = 32'd9;
        tick(1);
        send_pixels(3, 0);
        chk("mid_owrite", {31'd0, owrite}, 32'd1);
        chk("mid_busy", {31'd0, obusy}, 32'd1);
        irst = 1'b1;
        tick(1);
        chk("rst2_owrite", {31'd0, owrite}, 32'd0);
        chk("rst2_busy", {31'd0, obusy}, 32'd0);
        chk("rst2_ovf", {31'd0, ooverflow2}, 32'd0);
        chk("rst2_done", {31'd0, oframe_done}, 32'd0);
        irst = 1'b0; iwaitrequest = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
